// File: rtl/uart_frame_scheduler.sv
// Two-source frame scheduler: grants one byte-stream requester, loads its frame into the
// launch RAM, runs the launcher until its address counter reaches the frame length, then flushes the UART.
module uart_frame_scheduler #(
  parameter int CLK_RATE  = 100000000,
  parameter int BAUD_RATE = 9600,
  parameter int MAX_LEN   = 254
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       s0_valid_i,
  input  logic [7:0] s0_data_i,
  input  logic       s0_last_i,
  output logic       s0_ready_o,
  input  logic       s1_valid_i,
  input  logic [7:0] s1_data_i,
  input  logic       s1_last_i,
  output logic       s1_ready_o,
  output logic       l_en_w_o,
  output logic [7:0] l_w_addr_o,
  output logic [7:0] l_data_o,
  output logic       en_launch_o,
  input  logic [7:0] l_addr_counter_i,
  output logic       uart_rst_o,
  output logic [1:0] grant_o,
  output logic       busy_o,
  output logic       done_o,
  output logic       err_o,
  output logic       ovf_o,
  output logic [2:0] state_o
);
  localparam int BPS_TICKS = CLK_RATE / BAUD_RATE;
  localparam int FL_W      = (BPS_TICKS > 1) ? $clog2(BPS_TICKS) : 1;
  localparam int WD_TICKS  = 10 * BPS_TICKS;
  localparam int WD_W      = $clog2((MAX_LEN + 2) * WD_TICKS);
  localparam logic [8:0] MAX_LEN_V = 9'(MAX_LEN);

  typedef enum logic [2:0] {FLUSH, IDLE, LOAD, COMMIT, LAUNCH} state_t;
  typedef enum logic [1:0] {CAUSE_NONE, CAUSE_DONE, CAUSE_ERR} cause_t;

  // Handshake: a source byte transfers on a rising clk edge where its valid and ready are both high.
  state_t            state_q, state_d;
  cause_t            cause_q;
  logic [1:0]        grant_q;
  logic              last_s1_q;
  logic [8:0]        len_q;
  logic              ovf_q;
  logic [FL_W-1:0]   fl_cnt_q;
  logic [WD_W-1:0]   wd_q;
  logic [7:0]        samp1_q, samp2_q;
  logic              hit_q;
  logic              hs, hs_last, fl_end, s_ge, launch_done, wd_exp;
  logic [7:0]        hs_data;
  logic [31:0]       wd_lim;

  assign hs      = (state_q == LOAD) &
                   ((grant_q[0] & s0_valid_i) | (grant_q[1] & s1_valid_i));
  assign hs_data = grant_q[1] ? s1_data_i : s0_data_i;
  assign hs_last = grant_q[1] ? s1_last_i : s0_last_i;
  assign fl_end  = (fl_cnt_q == FL_W'(BPS_TICKS - 1));
  assign s_ge    = ({1'b0, samp2_q} >= len_q);
  assign launch_done = s_ge & hit_q;
  assign wd_lim  = (32'(len_q) + 32'd2) * 32'(WD_TICKS);
  assign wd_exp  = (32'(wd_q) == (wd_lim - 32'd1));

  assign grant_o = grant_q;
  assign busy_o  = (state_q != IDLE);
  assign state_o = state_q;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) state_q <= FLUSH;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d     = state_q;
    s0_ready_o  = 1'b0;
    s1_ready_o  = 1'b0;
    en_launch_o = 1'b0;
    uart_rst_o  = 1'b0;
    ovf_o       = 1'b0;
    case (state_q)
      FLUSH: begin
        uart_rst_o = 1'b1;
        if (fl_end) state_d = IDLE;
      end
      IDLE: if (s0_valid_i || s1_valid_i) state_d = LOAD;
      LOAD: begin
        s0_ready_o = grant_q[0];
        s1_ready_o = grant_q[1];
        if (hs && hs_last) state_d = COMMIT;
      end
      COMMIT: begin
        ovf_o   = ovf_q;
        state_d = LAUNCH;
      end
      LAUNCH: begin
        en_launch_o = 1'b1;
        if (launch_done || wd_exp) state_d = FLUSH;
      end
      default: state_d = FLUSH;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      cause_q    <= CAUSE_NONE;
      grant_q    <= 2'b00;
      last_s1_q  <= 1'b1;  // pretend s1 went last so s0 wins the first tie
      len_q      <= '0;
      ovf_q      <= 1'b0;
      fl_cnt_q   <= '0;
      wd_q       <= '0;
      samp1_q    <= '0;
      samp2_q    <= '0;
      hit_q      <= 1'b0;
      l_en_w_o   <= 1'b0;
      l_w_addr_o <= '0;
      l_data_o   <= '0;
      done_o     <= 1'b0;
      err_o      <= 1'b0;
    end else begin
      l_en_w_o <= 1'b0;
      done_o   <= 1'b0;
      err_o    <= 1'b0;
      samp1_q  <= l_addr_counter_i;
      samp2_q  <= samp1_q;
      hit_q    <= (state_q == LAUNCH) && s_ge;
      case (state_q)
        FLUSH: begin
          fl_cnt_q <= fl_cnt_q + 1'b1;
          if (fl_end) begin
            fl_cnt_q <= '0;
            done_o   <= (cause_q == CAUSE_DONE);
            err_o    <= (cause_q == CAUSE_ERR);
            cause_q  <= CAUSE_NONE;
            if (grant_q != 2'b00) last_s1_q <= grant_q[1];
            grant_q  <= 2'b00;
          end
        end
        IDLE: begin
          len_q <= '0;
          ovf_q <= 1'b0;
          if (s0_valid_i && s1_valid_i) grant_q <= last_s1_q ? 2'b01 : 2'b10;
          else if (s0_valid_i)          grant_q <= 2'b01;
          else if (s1_valid_i)          grant_q <= 2'b10;
        end
        LOAD: begin
          if (hs) begin
            if (len_q < MAX_LEN_V) begin
              l_en_w_o   <= 1'b1;
              l_w_addr_o <= len_q[7:0];
              l_data_o   <= hs_data;
              len_q      <= len_q + 9'd1;
            end else begin
              ovf_q <= 1'b1;
            end
          end
        end
        COMMIT: wd_q <= '0;
        LAUNCH: begin
          wd_q <= wd_q + 1'b1;
          if (launch_done) cause_q <= CAUSE_DONE;
          else if (wd_exp) cause_q <= CAUSE_ERR;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_uart_frame_scheduler.sv
// Self-checking bench for uart_frame_scheduler with a short BPS period (10 clocks)
// and a behavioural launcher address counter.
module tb_uart_frame_scheduler;
  localparam int CLK_RATE  = 1000;
  localparam int BAUD_RATE = 100;
  localparam int MAX_LEN   = 254;
  localparam int BPS       = CLK_RATE / BAUD_RATE;

  logic       clk = 1'b0;
  logic       rst_i = 1'b1;
  logic       s0_valid_i = 1'b0, s1_valid_i = 1'b0;
  logic [7:0] s0_data_i = '0, s1_data_i = '0;
  logic       s0_last_i = 1'b0, s1_last_i = 1'b0;
  logic       s0_ready_o, s1_ready_o;
  logic       l_en_w_o, en_launch_o, uart_rst_o, busy_o, done_o, err_o, ovf_o;
  logic [7:0] l_w_addr_o, l_data_o;
  logic [7:0] l_addr_counter_i = '0;
  logic [1:0] grant_o;
  logic [2:0] state_o;

  int n_tests = 0, n_fail = 0;
  int cyc = 0;
  logic [47:0] exp_q[$];  // {cycle, addr, data} of each expected RAM write
  int tb_len, hs_cnt;
  int done_cnt = 0, err_cnt = 0, ovf_cnt = 0, wr_cnt = 0;
  logic [7:0] lcnt = '0;
  int ldiv = 0, peak = 0;
  bit hold = 1'b0;

  uart_frame_scheduler #(.CLK_RATE(CLK_RATE), .BAUD_RATE(BAUD_RATE), .MAX_LEN(MAX_LEN)) dut (
    .clk_i(clk), .rst_i(rst_i),
    .s0_valid_i(s0_valid_i), .s0_data_i(s0_data_i), .s0_last_i(s0_last_i), .s0_ready_o(s0_ready_o),
    .s1_valid_i(s1_valid_i), .s1_data_i(s1_data_i), .s1_last_i(s1_last_i), .s1_ready_o(s1_ready_o),
    .l_en_w_o(l_en_w_o), .l_w_addr_o(l_w_addr_o), .l_data_o(l_data_o),
    .en_launch_o(en_launch_o), .l_addr_counter_i(l_addr_counter_i),
    .uart_rst_o(uart_rst_o), .grant_o(grant_o), .busy_o(busy_o),
    .done_o(done_o), .err_o(err_o), .ovf_o(ovf_o), .state_o(state_o)
  );

  // clock / cycle counter
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #3000000;
    $display("FAIL global_timeout at cycle %0d", cyc);
    $fatal(1, "bench timeout");
  end

  // launcher model: advances once per BPS period while enabled, cleared by the UART reset
  always @(negedge clk) begin
    if (uart_rst_o) begin
      lcnt = '0; ldiv = 0;
    end else if (en_launch_o && !hold) begin
      if (ldiv == BPS - 1) begin
        ldiv = 0;
        if (lcnt != 8'hff) lcnt = lcnt + 8'd1;
        if (int'(lcnt) > peak) peak = int'(lcnt);
      end else ldiv++;
    end
    l_addr_counter_i = lcnt;
  end

  // scoreboard: every RAM write must match the head of exp_q, cycle included
  always @(negedge clk) begin
    logic [47:0] e;
    if (done_o === 1'b1) done_cnt++;
    if (err_o === 1'b1) err_cnt++;
    if (ovf_o === 1'b1) ovf_cnt++;
    if (l_en_w_o === 1'b1) begin
      wr_cnt++;
      n_tests++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL ram_write unexpected got addr=%0d data=%h exp none", l_w_addr_o, l_data_o);
      end else begin
        e = exp_q.pop_front();
        if ({32'(cyc), l_w_addr_o, l_data_o} !== e) begin
          n_fail++;
          $display("FAIL ram_write got cyc=%0d addr=%0d data=%h exp cyc=%0d addr=%0d data=%h",
                   cyc, l_w_addr_o, l_data_o, e[47:16], e[15:8], e[7:0]);
        end
      end
    end
  end

  // driver tasks
  task automatic send_byte(input int src, input logic [7:0] d, input bit last);
    int g = 0;
    if (src == 0) begin s0_valid_i = 1'b1; s0_data_i = d; s0_last_i = last; end
    else          begin s1_valid_i = 1'b1; s1_data_i = d; s1_last_i = last; end
    forever begin
      @(negedge clk);
      n_tests++;
      if ((src == 0 ? s1_ready_o : s0_ready_o) !== 1'b0) begin
        n_fail++; $display("FAIL other_ready src=%0d got=1 exp=0", src);
      end
      if ((src == 0 ? s0_ready_o : s1_ready_o) === 1'b1) break;
      g++;
      if (g > 50) begin
        n_tests++; n_fail++;
        $display("FAIL ready_timeout src=%0d got=no_ready exp=ready", src);
        return;
      end
    end
    n_tests++;
    if (grant_o !== (src == 0 ? 2'b01 : 2'b10)) begin
      n_fail++; $display("FAIL grant src=%0d got=%b exp=%b", src, grant_o, (src == 0 ? 2'b01 : 2'b10));
    end
    @(posedge clk); #1;
    hs_cnt++;
    if (tb_len < MAX_LEN) begin
      exp_q.push_back({32'(cyc), 8'(tb_len), d});
      tb_len++;
    end
  endtask

  task automatic send_frame(input int src, input int n, input int base, input int step);
    tb_len = 0; hs_cnt = 0;
    for (int i = 0; i < n; i++) send_byte(src, 8'(base + i * step), (i == n - 1));
    if (src == 0) begin s0_valid_i = 1'b0; s0_last_i = 1'b0; end
    else          begin s1_valid_i = 1'b0; s1_last_i = 1'b0; end
    n_tests++;
    if (hs_cnt != n) begin n_fail++; $display("FAIL accepted got=%0d exp=%0d", hs_cnt, n); end
  endtask

  // Called right after the last handshake; returns #1 after the first IDLE negedge.
  task automatic finish_frame(input int len, input bit exp_ovf, input bit exp_err);
    int lc = 0, fc = 1, d0, e0, o0;
    d0 = done_cnt; e0 = err_cnt; o0 = ovf_cnt; peak = 0;
    @(negedge clk);
    n_tests++;
    if (en_launch_o !== 1'b0 || ovf_o !== exp_ovf) begin
      n_fail++; $display("FAIL commit got en=%b ovf=%b exp en=0 ovf=%b", en_launch_o, ovf_o, exp_ovf);
    end
    forever begin
      @(negedge clk);
      if (en_launch_o !== 1'b1) break;
      lc++;
      if (lc > 40000) break;
    end
    n_tests++;
    if (uart_rst_o !== 1'b1 || en_launch_o !== 1'b0) begin
      n_fail++; $display("FAIL flush_start got rst=%b en=%b exp rst=1 en=0", uart_rst_o, en_launch_o);
    end
    n_tests++;
    if (exp_err) begin
      if (lc != (len + 2) * 10 * BPS) begin
        n_fail++; $display("FAIL watchdog_cycles got=%0d exp=%0d", lc, (len + 2) * 10 * BPS);
      end
    end else if (lc < len * BPS || lc > len * BPS + 8 || peak < len) begin
      n_fail++; $display("FAIL launch_cycles got=%0d peak=%0d exp=%0d..%0d peak>=%0d",
                         lc, peak, len * BPS, len * BPS + 8, len);
    end
    forever begin
      @(negedge clk);
      if (uart_rst_o !== 1'b1) break;
      fc++;
      if (fc > 10 * BPS) break;
    end
    n_tests++;
    if (fc != BPS) begin n_fail++; $display("FAIL flush_len got=%0d exp=%0d", fc, BPS); end
    n_tests++;
    if (done_o !== !exp_err || err_o !== exp_err || busy_o !== 1'b0 || grant_o !== 2'b00) begin
      n_fail++; $display("FAIL frame_end got done=%b err=%b busy=%b grant=%b exp done=%b err=%b busy=0 grant=00",
                         done_o, err_o, busy_o, grant_o, !exp_err, exp_err);
    end
    #1;
    n_tests++;
    if (done_cnt - d0 != int'(!exp_err) || err_cnt - e0 != int'(exp_err) || ovf_cnt - o0 != int'(exp_ovf)) begin
      n_fail++; $display("FAIL pulse_count got done=%0d err=%0d ovf=%0d exp done=%0d err=%0d ovf=%0d",
                         done_cnt - d0, err_cnt - e0, ovf_cnt - o0, !exp_err, exp_err, exp_ovf);
    end
    n_tests++;
    if (exp_q.size() != 0) begin n_fail++; $display("FAIL writes_left got=%0d exp=0", exp_q.size()); end
  endtask

  task automatic count_flush(output int fc);
    fc = 0;
    forever begin
      @(negedge clk);
      if (uart_rst_o !== 1'b1) break;
      fc++;
      if (fc > 10 * BPS) break;
    end
  endtask

  // scenarios
  task automatic test_reset();
    int fc;
    #2 rst_i = 1'b0;
    s0_valid_i = 1'b1;
    repeat (3) @(negedge clk);
    n_tests++;
    if (uart_rst_o !== 1'b1 || en_launch_o !== 1'b0 || l_en_w_o !== 1'b0 || grant_o !== 2'b00 ||
        s0_ready_o !== 1'b0 || done_o !== 1'b0 || err_o !== 1'b0 || ovf_o !== 1'b0) begin
      n_fail++; $display("FAIL reset_state got rst=%b en=%b we=%b grant=%b rdy=%b done=%b err=%b ovf=%b exp 1,0,0,00,0,0,0,0",
                         uart_rst_o, en_launch_o, l_en_w_o, grant_o, s0_ready_o, done_o, err_o, ovf_o);
    end
    s0_valid_i = 1'b0;
    @(posedge clk); #1 rst_i = 1'b1;
    count_flush(fc);
    n_tests++;
    if (fc != BPS) begin n_fail++; $display("FAIL reset_flush_len got=%0d exp=%0d", fc, BPS); end
    #1;
    n_tests++;
    if (busy_o !== 1'b0 || grant_o !== 2'b00 || done_cnt != 0 || err_cnt != 0) begin
      n_fail++; $display("FAIL post_reset_idle got busy=%b grant=%b done=%0d err=%0d exp 0,00,0,0",
                         busy_o, grant_o, done_cnt, err_cnt);
    end
  endtask

  task automatic test_basic();
    send_frame(0, 3, 8'h11, 8'h11);
    finish_frame(3, 1'b0, 1'b0);
  endtask

  task automatic test_overflow();
    int w0 = wr_cnt;
    send_frame(1, 300, 0, 1);
    finish_frame(254, 1'b1, 1'b0);
    n_tests++;
    if (wr_cnt - w0 != 254) begin n_fail++; $display("FAIL ovf_writes got=%0d exp=254", wr_cnt - w0); end
  endtask

  task automatic test_arbitration();
    for (int r = 0; r < 2; r++) begin
      s1_valid_i = 1'b1; s1_data_i = 8'(8'hA0 + r * 16); s1_last_i = 1'b0;
      send_frame(0, 2, 8'h30 + r, 1);
      finish_frame(2, 1'b0, 1'b0);
      send_frame(1, 2, 8'hA0 + r * 16, 1);
      finish_frame(2, 1'b0, 1'b0);
    end
  endtask

  task automatic test_watchdog();
    hold = 1'b1;
    send_frame(0, 1, 8'h5A, 0);
    finish_frame(1, 1'b0, 1'b1);
    hold = 1'b0;
  endtask

  task automatic test_reset_mid_launch();
    int fc, d0, e0;
    send_frame(0, 5, 8'h50, 1);
    repeat (12) @(negedge clk);
    d0 = done_cnt; e0 = err_cnt;
    #2 rst_i = 1'b0;
    #1;
    n_tests++;
    if (en_launch_o !== 1'b0 || uart_rst_o !== 1'b1 || l_en_w_o !== 1'b0 || s0_ready_o !== 1'b0) begin
      n_fail++; $display("FAIL async_reset got en=%b rst=%b we=%b rdy=%b exp 0,1,0,0",
                         en_launch_o, uart_rst_o, l_en_w_o, s0_ready_o);
    end
    @(posedge clk); #1 rst_i = 1'b1;
    count_flush(fc);
    #1;
    n_tests++;
    if (fc != BPS || done_cnt != d0 || err_cnt != e0) begin
      n_fail++; $display("FAIL abandon_flush got len=%0d done=%0d err=%0d exp len=%0d done=0 err=0",
                         fc, done_cnt - d0, err_cnt - e0, BPS);
    end
    s1_valid_i = 1'b1; s1_data_i = 8'h70; s1_last_i = 1'b0;
    send_frame(0, 2, 8'h60, 1);
    finish_frame(2, 1'b0, 1'b0);
    send_frame(1, 1, 8'h70, 0);
    finish_frame(1, 1'b0, 1'b0);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_overflow();
    test_arbitration();
    test_watchdog();
    test_reset_mid_launch();
    repeat (2) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/uart_frame_scheduler.md
# uart_frame_scheduler

Two-source frame scheduler sitting in front of the UART system's launch path. It grants one of two byte-stream requesters at a time, loads the granted frame into the launch RAM through its write port, and asserts launch enable until the launcher's address counter reaches the frame length. It then holds the UART system reset for one BPS period so that every frame starts from address 0, and reports done or error.

## Interface
- CLK_RATE, 100000000, system clock in Hz.
- BAUD_RATE, 9600, UART baud; BPS_TICKS = CLK_RATE/BAUD_RATE (10416 at defaults).
- MAX_LEN, 254, maximum stored frame bytes (1..255; the RAM is never filled).

- clk_i  in  1  system clock (CLK100MHZ domain).
- rst_i  in  1  asynchronous, active-low reset.
- s0_valid_i / s1_valid_i  in  1  source byte valid.
- s0_data_i / s1_data_i  in  8  source byte.
- s0_last_i / s1_last_i  in  1  marks final byte of frame.
- s0_ready_o / s1_ready_o  out  1  byte accepted when valid and ready are both high.
- l_en_w_o  out  1  launch RAM write enable.
- l_w_addr_o  out  8  launch RAM write address.
- l_data_o  out  8  launch RAM write data.
- en_launch_o  out  1  launcher enable.
- l_addr_counter_i  in  8  launcher's current read address (changes at BPS rate).
- uart_rst_o  out  1  active-high reset to the UART system.
- grant_o  out  2  one-hot current owner; 00 when idle.
- busy_o  out  1  state != IDLE.
- done_o  out  1  one-cycle pulse: frame fully sent.
- err_o  out  1  one-cycle pulse: launch watchdog expired.
- ovf_o  out  1  one-cycle pulse at frame end: bytes beyond MAX_LEN were dropped.

## Operation
- States: FLUSH, IDLE, LOAD, COMMIT, LAUNCH.
- Reset (async assert): state=FLUSH, uart_rst_o=1, flush counter=0. All other outputs 0, and the round-robin pointer favours s0.
- FLUSH: uart_rst_o=1 for exactly BPS_TICKS cycles, then go to IDLE. On exit, pulse done_o or err_o if a frame caused the flush; no pulse for the post-reset flush.
- IDLE: if any valid is high, latch the grant and go to LOAD.
  - Round-robin: if both valid, grant the source not served last.
  - Sample len=0.
- LOAD: ready is high only for the granted source.
  - Each handshake registers the byte. If len<MAX_LEN, next cycle l_en_w_o=1, l_w_addr_o=len, l_data_o=byte, and len increments. Otherwise the byte is dropped and the overflow flag is set.
  - A handshake with last=1 goes to COMMIT. Ready drops in the cycle after the last handshake.
- COMMIT: one cycle that carries the final registered write (if not dropped). Then go to LAUNCH and clear the watchdog.
- LAUNCH: en_launch_o=1.
  - l_addr_counter_i passes through a 2-flop sampler. Done when the sampled value is >= len on 2 consecutive cycles: deassert en_launch_o and go to FLUSH, then pulse done_o at FLUSH exit.
  - Watchdog limit = (len+2)*10*BPS_TICKS cycles. On expiry go to FLUSH and pulse err_o instead of done_o.
- ovf_o pulses in the COMMIT cycle if the overflow flag is set; the flag clears in IDLE.
- grant_o stays valid from LOAD through FLUSH exit. The pointer updates at FLUSH exit.
- Source valid/data changes outside its grant are ignored. A non-granted source waits with ready=0.

## Timing
- Handshake in cycle t → RAM write in t+1. Last handshake at t → COMMIT at t+1 → en_launch_o high from t+2.
- IDLE→LOAD: valid seen at t, grant_o and ready high at t+1. Minimum frame-to-frame gap = BPS_TICKS + 3 cycles.
- Width rules:
  - len is 9 bits internally, saturating at MAX_LEN.
  - Flush counter width is clog2(BPS_TICKS).
  - Watchdog width is clog2((MAX_LEN+2)*10*BPS_TICKS) (25 bits at defaults).
- len never wraps, and l_w_addr_o never exceeds MAX_LEN-1.
- Reset asserted mid-LOAD or mid-LAUNCH:
  - Immediately: en_launch_o=0, l_en_w_o=0, ready=0, uart_rst_o=1.
  - The partial frame is abandoned, with no done_o or err_o pulse.
- Simultaneous last handshake and reset: reset wins.

## Test plan
- Reset release → uart_rst_o high for exactly 10416 cycles, then IDLE with busy_o=0, grant_o=00, and no done_o.
- s0 sends 3 bytes 0x11,0x22,0x33 (last on 0x33) → writes at addresses 0,1,2 one cycle after each handshake. en_launch_o rises 2 cycles after the last handshake. When the model counter reaches 3, en_launch_o falls, uart_rst_o is high for 10416 cycles, then a single done_o pulse.
- s0 and s1 both valid from IDLE → s0 served first, then s1. Then both valid again → s0 (alternation 0,1,0). s1_ready_o stays 0 throughout s0's frame.
- s1 sends 300 bytes with MAX_LEN=254 → exactly 254 writes (addresses 0..253) and all 300 bytes accepted. ovf_o pulses once, and launch completes at counter 254.
- 1-byte frame with the counter held at 0 → err_o after exactly 3*10*10416 = 312480 LAUNCH cycles, then flush, and done_o never pulses.
- rst_i low during LAUNCH of a 5-byte frame → en_launch_o=0 and uart_rst_o=1 asynchronously. After release, the flush completes with no done_o/err_o, and the next grant goes to s0.
